cordic_vectoring: RTL and testbench

// Iterative vectoring-mode CORDIC, the inverse of the rotation-mode cordic core: takes a

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_vec_step.sv | 38 +++
 rtl/cordic_vectoring.sv | 156 +++++++++++++++
 tb/tb_cordic_vectoring.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: Q4.28 arctangent table, pi/2, inverse gain and FSM encodings.
// Imported by both the rotation and the vectoring cores.
package cordic_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned INT_W     = 4;
    localparam int unsigned FRAC_W    = DATA_W - INT_W;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned TABLE_LEN = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;

    localparam logic [DATA_W-1:0] PI_HALF = 32'h1921FB54;
    localparam logic [DATA_W-1:0] INV_K   = 32'h09B74EDA;

    // atan(2^-i) in Q4.28, rounded to nearest
    localparam logic [DATA_W-1:0] ATAN_TABLE [0:TABLE_LEN-1] = '{
        32'h0C90FDAA, 32'h076B19C1, 32'h03EB6EBF, 32'h01FD5BAA,
        32'h00FFAADE, 32'h007FF557, 32'h003FFEAB, 32'h001FFFD5,
        32'h000FFFFB, 32'h0007FFFF, 32'h00040000, 32'h00020000,
        32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000,
        32'h00001000, 32'h00000800, 32'h00000400, 32'h00000200,
        32'h00000100, 32'h00000080, 32'h00000040, 32'h00000020,
        32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002,
        32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000
    };

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring-mode micro-rotation: drives y toward zero and accumulates the
// rotated angle in z. Purely combinational.
module cordic_vec_step
    import cordic_pkg::*;
#(
    parameter int unsigned W = DATA_W + 2
) (
    input  logic signed [W-1:0]     i_x,
    input  logic signed [W-1:0]     i_y,
    input  logic signed [W-1:0]     i_z,
    input  logic        [IDX_W-1:0] i_idx,
    output logic signed [W-1:0]     o_x,
    output logic signed [W-1:0]     o_y,
    output logic signed [W-1:0]     o_z
);

    logic signed [W-1:0] w_x_sh;
    logic signed [W-1:0] w_y_sh;
    logic signed [W-1:0] w_atan;

    assign w_x_sh = i_x >>> i_idx;
    assign w_y_sh = i_y >>> i_idx;
    assign w_atan = $signed(W'(ATAN_TABLE[i_idx]));

    // y negative: rotate counter-clockwise (d=+1), otherwise clockwise
    always_comb begin
        if (i_y[W-1]) begin
            o_x = i_x - w_y_sh;
            o_y = i_y + w_x_sh;
            o_z = i_z - w_atan;
        end else begin
            o_x = i_x + w_y_sh;
            o_y = i_y - w_x_sh;
            o_z = i_z + w_atan;
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x0,y0) in Q4.28 -> magnitude and atan2 angle,
// one micro-rotation per clock, start/end-of-conversion handshake.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int unsigned n    = DATA_W,
    parameter int unsigned m    = INT_W,
    parameter int unsigned ITER = 28
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         stc_i,
    input  logic [n-1:0] x0_i,
    input  logic [n-1:0] y0_i,
    output logic         eoc_o,
    output logic [n-1:0] xn_o,
    output logic [n-1:0] zn_o
);

    localparam int unsigned W      = n + 2;
    localparam int unsigned FRAC   = n - m;
    localparam int unsigned PROD_W = W + n + 1;

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_i;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic signed [W-1:0] r_z;
    logic                r_eoc;
    logic [n-1:0]        r_xn;
    logic [n-1:0]        r_zn;

    logic [1:0]          w_state_nxt;
    logic [IDX_W-1:0]    w_i_nxt;
    logic signed [W-1:0] w_x_nxt;
    logic signed [W-1:0] w_y_nxt;
    logic signed [W-1:0] w_z_nxt;
    logic                w_eoc_nxt;
    logic [n-1:0]        w_xn_nxt;
    logic [n-1:0]        w_zn_nxt;

    logic signed [W-1:0] w_x0;
    logic signed [W-1:0] w_y0;
    logic signed [W-1:0] w_pi_half;
    logic signed [W-1:0] w_step_x;
    logic signed [W-1:0] w_step_y;
    logic signed [W-1:0] w_step_z;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_scaled;
    logic                     w_sat;
    logic [n-1:0]             w_xn_scaled;
    logic                     w_unused_z_hi;

    assign w_x0      = W'($signed(x0_i));
    assign w_y0      = W'($signed(y0_i));
    assign w_pi_half = $signed(W'(PI_HALF));

    cordic_vec_step #(
        .W (W)
    ) u_step (
        .i_x   (r_x),
        .i_y   (r_y),
        .i_z   (r_z),
        .i_idx (r_i),
        .o_x   (w_step_x),
        .o_y   (w_step_y),
        .o_z   (w_step_z)
    );

    // Gain compensation; x is non-negative after vectoring so only the upper bound clamps
    assign w_prod      = PROD_W'(r_x) * PROD_W'($signed({1'b0, INV_K}));
    assign w_scaled    = w_prod >>> FRAC;
    assign w_sat       = !w_scaled[PROD_W-1] && (|w_scaled[PROD_W-2:n-1]);
    assign w_xn_scaled = w_sat ? {1'b0, {(n-1){1'b1}}} : w_scaled[n-1:0];

    assign w_unused_z_hi = ^r_z[W-1:n];

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_z_nxt     = r_z;
        w_eoc_nxt   = 1'b0;
        w_xn_nxt    = r_xn;
        w_zn_nxt    = r_zn;
        case (r_state)
            S_IDLE: begin
                if (stc_i) begin
                    w_i_nxt     = '0;
                    w_state_nxt = S_ITER;
                    // Pre-rotate left half-plane inputs by +-90 degrees into x >= 0
                    if (!x0_i[n-1]) begin
                        w_x_nxt = w_x0;
                        w_y_nxt = w_y0;
                        w_z_nxt = '0;
                    end else if (!y0_i[n-1]) begin
                        w_x_nxt = w_y0;
                        w_y_nxt = -w_x0;
                        w_z_nxt = w_pi_half;
                    end else begin
                        w_x_nxt = -w_y0;
                        w_y_nxt = w_x0;
                        w_z_nxt = -w_pi_half;
                    end
                end
            end
            S_ITER: begin
                w_x_nxt = w_step_x;
                w_y_nxt = w_step_y;
                w_z_nxt = w_step_z;
                w_i_nxt = r_i + IDX_W'(1);
                if (r_i == IDX_W'(ITER - 1)) begin
                    w_state_nxt = S_SCALE;
                end
            end
            S_SCALE: begin
                w_xn_nxt    = w_xn_scaled;
                w_zn_nxt    = r_z[n-1:0];
                w_eoc_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_eoc   <= 1'b0;
            r_xn    <= '0;
            r_zn    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_z     <= w_z_nxt;
            r_eoc   <= w_eoc_nxt;
            r_xn    <= w_xn_nxt;
            r_zn    <= w_zn_nxt;
        end
    end

    assign eoc_o = r_eoc;
    assign xn_o  = r_xn;
    assign zn_o  = r_zn;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: directed vectors push expected results,
// an independent monitor checks them (and the eoc timing) whenever eoc_o fires.
module tb_cordic_vectoring;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stc_i;
    logic [31:0] x0_i;
    logic [31:0] y0_i;
    logic        eoc_o;
    logic [31:0] xn_o;
    logic [31:0] zn_o;

    always #5 clk = ~clk;

    cordic_vectoring dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .stc_i (stc_i),
        .x0_i  (x0_i),
        .y0_i  (y0_i),
        .eoc_o (eoc_o),
        .xn_o  (xn_o),
        .zn_o  (zn_o)
    );

    typedef struct {
        logic [31:0] xn;
        logic [31:0] zn;
        bit          chk_zn;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   prev_eoc = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit near(input logic [31:0] act, input logic [31:0] exp);
        logic signed [31:0] d;
        d = $signed(act - exp);
        return (d <= 32'sd64) && (d >= -32'sd64);
    endfunction

    task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!near(act, exp)) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (+-64 LSB)", name, act, exp);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every eoc pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (eoc_o === 1'b1) begin
            exp_t e;
            check_eq("eoc_single_cycle", {31'b0, prev_eoc}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_eoc: got eoc at cycle %0d, want none", cyc);
            end else begin
                e = sb.pop_front();
                check_eq("eoc_latency", 32'(cyc), 32'(e.cyc));
                check_near("xn", xn_o, e.xn);
                if (e.chk_zn) check_near("zn", zn_o, e.zn);
            end
        end
        prev_eoc <= eoc_o;
    end

    // Called at a negedge; the following posedge is the start edge E0
    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] xn_e, input logic [31:0] zn_e, input bit chk_zn);
        exp_t e;
        x0_i     = x;
        y0_i     = y;
        stc_i    = 1'b1;
        e.xn     = xn_e;
        e.zn     = zn_e;
        e.chk_zn = chk_zn;
        e.cyc    = cyc + 30;
        sb.push_back(e);
        @(negedge clk);
        stc_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle_timeout: got %0d results pending, want 0", sb.size());
        sb.delete();
    endtask

    task automatic wait_eoc(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (eoc_o === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_eoc_timeout: got no eoc in %0d cycles, want one", max_cyc);
    endtask

    initial begin
        bit ok;
        rst_i = 1'b1;
        stc_i = 1'b0;
        x0_i  = '0;
        y0_i  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_eoc", {31'b0, eoc_o}, 32'd0);
        check_eq("rst_xn", xn_o, 32'd0);
        check_eq("rst_zn", zn_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // (1,0); a second start and changed inputs mid-run must be ignored
        issue(32'h10000000, 32'h00000000, 32'h10000000, 32'h00000000, 1'b1);
        repeat (8) @(negedge clk);
        x0_i  = 32'hF0000000;
        y0_i  = 32'h10000000;
        stc_i = 1'b1;
        @(negedge clk);
        stc_i = 1'b0;
        wait_idle(60);

        // (1,1), then (-1,0) started in the eoc cycle
        issue(32'h10000000, 32'h10000000, 32'h16A09E66, 32'h0C90FDAA, 1'b1);
        wait_eoc(60, ok);
        if (ok) begin
            issue(32'hF0000000, 32'h00000000, 32'h10000000, 32'h3243F6A8, 1'b1);
            repeat (10) @(negedge clk);
            check_near("hold_xn", xn_o, 32'h16A09E66);
            check_near("hold_zn", zn_o, 32'h0C90FDAA);
        end
        wait_idle(60);

        // (0,-1) -> -pi/2
        issue(32'h00000000, 32'hF0000000, 32'h10000000, 32'hE6DE04AC, 1'b1);
        wait_idle(60);

        // (-1,-1) -> -3pi/4, sqrt2
        issue(32'hF0000000, 32'hF0000000, 32'h16A09E66, 32'hDA4D0702, 1'b1);
        wait_idle(60);

        // (0,0): magnitude stays zero
        issue(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0);
        wait_idle(60);

        // Reset between edges in the middle of ITER
        issue(32'hF0000000, 32'h00000000, 32'h10000000, 32'h3243F6A8, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        rst_i = 1'b1;
        sb.delete();
        #1;
        check_eq("midrst_eoc", {31'b0, eoc_o}, 32'd0);
        check_eq("midrst_xn", xn_o, 32'd0);
        check_eq("midrst_zn", zn_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (40) @(negedge clk);

        issue(32'h10000000, 32'h10000000, 32'h16A09E66, 32'h0C90FDAA, 1'b1);
        wait_idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
